// File: rtl/dm_cache_ctrl_if.sv
// CPU load/store port and main-memory block port of the direct-mapped cache controller.
// The controller takes the slave view; the CPU and memory side together take the master view.
interface dm_cache_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_ready;
   logic              mem_readWrite;
   logic [ADDR_W-1:0] mem_addr;
   logic [127:0]      mem_writeData;
   logic [127:0]      mem_readData;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      input  mem_readWrite, mem_addr, mem_writeData,
      output mem_readData
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready,
      output mem_readWrite, mem_addr, mem_writeData,
      input  mem_readData
   );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// A miss evicts a dirty victim, refills the line, then retries the compare.
module dm_cache_ctrl #(
   parameter int NUM_LINES = 4,
   parameter int MEM_LAT   = 4,
   parameter int ADDR_W    = 10
) (
   input  logic          clock,
   input  logic          reset,
   dm_cache_ctrl_if.slave bus,
   output logic [15:0]   hit_count,
   output logic [15:0]   miss_count
);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - 4 - IDX_W;
   localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} stateType;

   stateType state, stateNext;

   logic [NUM_LINES-1:0] validBits, dirtyBits;
   logic [TAG_W-1:0]     tagArr  [NUM_LINES];
   logic [127:0]         dataArr [NUM_LINES];

   logic [ADDR_W-1:0] reqAddr;
   logic              reqWe;
   logic [31:0]       reqWdata;
   logic [WAIT_W-1:0] waitCnt;
   logic              retry;

   logic [IDX_W-1:0] reqIdx;
   logic [TAG_W-1:0] reqTag;
   logic [1:0]       reqWord;
   logic             hit, victimDirty, waitDone, fillNow, storeHit;

   assign reqIdx      = reqAddr[4+IDX_W-1:4];
   assign reqTag      = reqAddr[ADDR_W-1:4+IDX_W];
   assign reqWord     = reqAddr[3:2];
   assign hit         = validBits[reqIdx] && (tagArr[reqIdx] == reqTag);
   assign victimDirty = validBits[reqIdx] && dirtyBits[reqIdx];
   assign waitDone    = (waitCnt == '0);
   assign fillNow     = (state == ALLOCATE) && waitDone;
   assign storeHit    = (state == COMPARE) && hit && reqWe;

   // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // NOTE: stateNext gets its default first, so no path leaves it unassigned (no latch).
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:      if (bus.cpu_req) stateNext = COMPARE;
         COMPARE:   stateNext = hit ? IDLE : (victimDirty ? WRITEBACK : ALLOCATE);
         WRITEBACK: if (waitDone) stateNext = ALLOCATE;
         ALLOCATE:  if (waitDone) stateNext = COMPARE;
         default:   stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         validBits         <= '0;
         dirtyBits         <= '0;
         reqAddr           <= '0;
         reqWe             <= 1'b0;
         reqWdata          <= '0;
         waitCnt           <= '0;
         retry             <= 1'b0;
         hit_count         <= '0;
         miss_count        <= '0;
         bus.cpu_ready     <= 1'b0;
         bus.cpu_rdata     <= '0;
         bus.mem_readWrite <= 1'b0;
         bus.mem_addr      <= '0;
         bus.mem_writeData <= '0;
      end else begin
         bus.cpu_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cpu_req) begin
                  reqAddr  <= bus.cpu_addr;
                  reqWe    <= bus.cpu_we;
                  reqWdata <= bus.cpu_wdata;
               end
            end
            COMPARE: begin
               retry <= 1'b0;
               if (hit) begin
                  bus.cpu_ready <= 1'b1;
                  if (reqWe) dirtyBits[reqIdx] <= 1'b1;
                  else       bus.cpu_rdata <= dataArr[reqIdx][{reqWord, 5'b0} +: 32];
                  if (!retry && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
               end else begin
                  if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                  waitCnt <= WAIT_LOAD;
                  if (victimDirty) begin
                     bus.mem_readWrite <= 1'b1;
                     bus.mem_addr      <= {tagArr[reqIdx], reqIdx, 4'b0000};
                     bus.mem_writeData <= dataArr[reqIdx];
                  end else begin
                     bus.mem_addr <= {reqAddr[ADDR_W-1:4], 4'b0000};
                  end
               end
            end
            WRITEBACK: begin
               if (waitDone) begin
                  bus.mem_readWrite <= 1'b0;
                  bus.mem_addr      <= {reqAddr[ADDR_W-1:4], 4'b0000};
                  waitCnt           <= WAIT_LOAD;
               end else begin
                  waitCnt <= waitCnt - 1'b1;
               end
            end
            ALLOCATE: begin
               if (waitDone) begin
                  validBits[reqIdx] <= 1'b1;
                  dirtyBits[reqIdx] <= 1'b0;
                  retry             <= 1'b1;
               end else begin
                  waitCnt <= waitCnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: tag/data storage has no reset; the valid bits alone decide whether its contents count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (fillNow) begin
            dataArr[reqIdx] <= bus.mem_readData;
            tagArr[reqIdx]  <= reqTag;
         end else if (storeHit) begin
            dataArr[reqIdx][{reqWord, 5'b0} +: 32] <= reqWdata;
         end
      end
   end
endmodule
